cla_nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice.
- A small FSM steps the slice across the operands one nibble per cycle, least significant nibble first. A registered carry links each nibble to the next.
- Used where area matters more than latency: datapath accumulators and address-offset units.
- Gives a start/done handshake and status flags for the sequencing logic above it.

---
 rtl/cla_nibble_serial_adder.sv | 135 +++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
`timescale 1ns/1ps
// cla_nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. One 4-bit carry-lookahead slice
//   is stepped across the operands one nibble per cycle, least significant
//   nibble first. A registered carry links each nibble to the next.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request pulse, accepted in IDLE or DONE
//   op_sub  0: a_in + b_in + cin_in, 1: a_in - b_in (sampled with start)
//   a_in    operand A (sampled with start)
//   b_in    operand B (sampled with start)
//   cin_in  carry-in for add, ignored for subtract (sampled with start)
//   busy    high while the slice is stepping (NIB cycles)
//   done    one-cycle pulse when sum/flags are updated
//   sum     registered result, modulo 2^WIDTH
//   cout    carry out of the MSB (subtract: 1 = no borrow)
//   ovf     signed overflow
//   zero    sum == 0
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  // 4-bit carry-lookahead slice. Returns {c3, c2, s[3:0]}; c2 is kept so the
  // final nibble can derive signed overflow (carry into MSB vs carry out).
  function automatic logic [5:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       cin);
    logic [3:0] p, g, s;
    logic       c0, c1, c2, c3;
    p  = a ^ b;
    g  = a & b;
    c0 = g[0] | (p[0] & cin);
    c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cin);
    s  = p ^ {c2, c1, c0, cin};
    return {c3, c2, s};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             c_r;
  logic [5:0]       slice;
  logic [WIDTH-1:0] final_sum;

  assign slice = cla4(a_r[{idx, 2'b00} +: 4], b_r[{idx, 2'b00} +: 4], c_r);

  // The last nibble goes straight into the result register together with the
  // lower nibbles already held in the shadow.
  always_comb begin
    final_sum               = res_r;
    final_sum[WIDTH-1 -: 4] = slice[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= 1'b0;
      res_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is A + ~B + 1.
            a_r   <= a_in;
            b_r   <= op_sub ? ~b_in : b_in;
            c_r   <= op_sub ? 1'b1 : cin_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_r[{idx, 2'b00} +: 4] <= slice[3:0];
          c_r                      <= slice[5];
          if (idx == LAST) begin
            sum   <= final_sum;
            cout  <= slice[5];
            ovf   <= slice[5] ^ slice[4];
            zero  <= (final_sum == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
`timescale 1ns/1ps
module tb_cla_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] sum;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract, result {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
    longint ua, ub, sa, sb, ur, sr;
    logic [W-1:0] s;
    logic co, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      co = (ur >= (longint'(1) << W));
    end
    s  = ur[W-1:0];
    ov = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    return {ov, co, s};
  endfunction

  // Behavioural model: a countdown of the cycles an accepted request takes;
  // results appear when it expires.
  int           m_cnt = 0;
  logic         m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W+1:0] m_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_zero <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_sum  <= m_pend[W-1:0];
        m_cout <= m_pend[W];
        m_ovf  <= m_pend[W+1];
        m_zero <= (m_pend[W-1:0] == '0);
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref_op(a_in, b_in, op_sub, cin_in);
        m_cnt  <= NIB;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("cycle{busy,done,cout,ovf,zero,sum}",
          64'({busy, done, cout, ovf, zero, sum}),
          64'({m_cnt != 0, m_done, m_cout, m_ovf, m_zero, m_sum}));
  end

  // Directed operation with literal expectations. Returns at the negedge of
  // the done cycle so a caller can start back-to-back.
  task automatic run_dir(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input logic ez, input bit repulse, input bit b2b,
                         input logic [W-1:0] prev);
    int lat, bcnt;
    bit got;
    lat = 0; bcnt = 0; got = 1'b0;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; a_in = a; b_in = b; op_sub = sub; cin_in = cin;
    @(posedge clk);
    #1;
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); op_sub = ~sub;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (b2b && i == 2) chk("hold_prev_sum", 64'(sum), 64'(prev));
      if (repulse && i == 1) begin
        start = 1'b1; a_in = 16'h0101; b_in = 16'h0202; op_sub = 1'b0;
      end
      if (repulse && i == 2) start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("done_latency", 64'(lat), 64'(NIB + 1));
    chk("busy_cycles", 64'(bcnt), 64'(NIB));
    chk("sum", 64'(sum), 64'(es));
    chk("flags{cout,ovf,zero}", 64'({cout, ovf, zero}), 64'({ec, eo, ez}));
    chk("model_sum", 64'(m_sum), 64'(es));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [5];
    edges = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return W'($urandom);
  endfunction

  initial begin
    #1;
    reset = 1'b1;
    #20;
    chk_en = 1'b1;
    chk("reset_outputs", 64'({busy, done, cout, ovf, zero, sum}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    run_dir(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    run_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    run_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    run_dir(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    run_dir(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    run_dir(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    run_dir(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF);

    // Abort mid-operation while idx = 2.
    @(posedge clk);
    #1;
    start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; op_sub = 1'b0; cin_in = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_outputs", 64'({busy, done, cout, ovf, zero, sum}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_dir(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

    // Random traffic, including start during RUN and back-to-back requests.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      start  = ($urandom_range(3) == 0);
      a_in   = pick();
      b_in   = pick();
      op_sub = 1'($urandom);
      cin_in = 1'($urandom);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
